// File: rtl/ram_mp_pkg.sv
// -----------------------------------------------------------------------------
// ram_mp_pkg
// Shared definitions for the multi-read-port RAM:
//   - clear-engine FSM state encoding (ST_IDLE, ST_CLEAR)
//   - default address/data widths for the core memory map
// Imported by ram_clear_fsm and ram_mp.
// -----------------------------------------------------------------------------
package ram_mp_pkg;

  // Core memory map: 32 KiB of byte-wide storage.
  localparam int RAM_ADDR_W_DEF = 15;
  localparam int RAM_DATA_W_DEF = 8;

  // Upper bound on read ports supported by the read-port generate loop.
  localparam int RAM_MAX_RD_PORTS = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

endpackage : ram_mp_pkg

// File: rtl/ram_mp_clear_fsm.sv
// -----------------------------------------------------------------------------
// ram_clear_fsm
// Clear engine for ram_mp. After reset it sweeps every address once, issuing a
// zero write per cycle, and reports busy until the sweep finishes.
//
// Parameters:
//   ADDR_W          address width; the sweep covers 2^ADDR_W words
//   CLEAR_ON_RESET  1 = sweep after reset, 0 = go straight to IDLE
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset (restarts the sweep at 0)
//   busy      out  sweep in progress
//   clr_we    out  write strobe for the sweep write
//   clr_addr  out  address being cleared this cycle
// -----------------------------------------------------------------------------
module ram_clear_fsm
  import ram_mp_pkg::*;
#(
  parameter int ADDR_W         = RAM_ADDR_W_DEF,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  clr_state_t        state_reg;
  clr_state_t        state_next;
  logic [ADDR_W-1:0] ctr_reg;
  logic [ADDR_W-1:0] ctr_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      ctr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ctr_reg   <= ctr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ctr_next   = ctr_reg;
    clr_we     = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        clr_we   = 1'b1;
        ctr_next = ctr_reg + ADDR_W'(1);
        // The last word is written on this edge; busy falls with it.
        if (ctr_reg == {ADDR_W{1'b1}}) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy     = (state_reg == ST_CLEAR);
  assign clr_addr = ctr_reg;

endmodule : ram_clear_fsm

// File: rtl/ram_mp.sv
// -----------------------------------------------------------------------------
// ram_mp
// Multi-read-port synchronous RAM: one write port, RD_PORTS registered read
// ports, and a built-in clear engine that zeroes the array after reset.
//
// Parameters:
//   ADDR_W          address width, depth = 2^ADDR_W
//   DATA_W          word width
//   RD_PORTS        number of read ports (1..4)
//   CLEAR_ON_RESET  1 = zero the array after reset, 0 = no clear cycles
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset, highest priority
//   busy    out  clear in progress: writes ignored, reads not accepted
//   we      in   write enable
//   waddr   in   write address
//   wdata   in   write data
//   re      in   per-port read enable
//   raddr   in   read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata   out  registered read data, port i at [i*DATA_W +: DATA_W]
//   rvalid  out  per-port valid for rdata (one cycle after re)
//
// Configuration macro:
//   RAM_MP_WRITE_BYPASS_EN  defined: a read hitting the address being written
//                           in the same cycle returns wdata (write-first).
//                           undefined: such a read returns the old contents.
// -----------------------------------------------------------------------------
module ram_mp
  import ram_mp_pkg::*;
#(
  parameter int ADDR_W         = RAM_ADDR_W_DEF,
  parameter int DATA_W         = RAM_DATA_W_DEF,
  parameter int RD_PORTS       = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         busy,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            waddr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [RD_PORTS-1:0]          re,
  input  logic [RD_PORTS*ADDR_W-1:0]   raddr,
  output logic [RD_PORTS*DATA_W-1:0]   rdata,
  output logic [RD_PORTS-1:0]          rvalid
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  ram_clear_fsm #(
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // While busy the clear engine owns the write port; user writes are dropped.
  // rst blocks every write so a reset edge never disturbs the array.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    if (!rst) begin
      if (busy) begin
        mem_we    = clr_we;
        mem_waddr = clr_addr;
        mem_wdata = '0;
      end else begin
        mem_we = we;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
      logic [ADDR_W-1:0] port_addr;
      logic              rd_en;
      logic [DATA_W-1:0] rd_data_reg;
      logic              rd_valid_reg;

      assign port_addr = raddr[gi*ADDR_W +: ADDR_W];
      assign rd_en     = re[gi] & ~busy;

      // Nonblocking update against the write above gives read-old ordering
      // for a same-address read/write in one cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_reg  <= '0;
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= rd_en;
          if (rd_en) begin
            rd_data_reg <= mem[port_addr];
          end
        end
      end

`ifdef RAM_MP_WRITE_BYPASS_EN
      // Bypass capture: remember whether this read collided with the write and
      // what was written, then steer it onto the output after the RAM register.
      // Both registers only update on an accepted read so rdata holds with re=0.
      logic              byp_hit_reg;
      logic [DATA_W-1:0] byp_data_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          byp_hit_reg  <= 1'b0;
          byp_data_reg <= '0;
        end else if (rd_en) begin
          byp_hit_reg  <= we && (waddr == port_addr);
          byp_data_reg <= wdata;
        end
      end

      assign rdata[gi*DATA_W +: DATA_W] = byp_hit_reg ? byp_data_reg : rd_data_reg;
`else
      assign rdata[gi*DATA_W +: DATA_W] = rd_data_reg;
`endif

      assign rvalid[gi] = rd_valid_reg;
    end
  endgenerate

endmodule : ram_mp

// File: tb/tb_ram_mp.sv
// -----------------------------------------------------------------------------
// tb_ram_mp
// Self-checking bench for ram_mp. Main instance: ADDR_W=4, DATA_W=8,
// RD_PORTS=2, CLEAR_ON_RESET=1. Second instance: CLEAR_ON_RESET=0, one port.
// -----------------------------------------------------------------------------
module tb_ram_mp;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT
  logic        rst;
  logic        busy;
  logic        we;
  logic [3:0]  waddr;
  logic [7:0]  wdata;
  logic [1:0]  re;
  logic [7:0]  raddr;
  logic [15:0] rdata;
  logic [1:0]  rvalid;

  // No-clear DUT
  logic        rst2;
  logic        busy2;
  logic        we2;
  logic [3:0]  waddr2;
  logic [7:0]  wdata2;
  logic [0:0]  re2;
  logic [3:0]  raddr2;
  logic [7:0]  rdata2;
  logic [0:0]  rvalid2;

  ram_mp #(.ADDR_W(4), .DATA_W(8), .RD_PORTS(2), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .busy(busy), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid)
  );

  ram_mp #(.ADDR_W(4), .DATA_W(8), .RD_PORTS(1), .CLEAR_ON_RESET(0)) dut_nc (
    .clk(clk), .rst(rst2), .busy(busy2), .we(we2), .waddr(waddr2), .wdata(wdata2),
    .re(re2), .raddr(raddr2), .rdata(rdata2), .rvalid(rvalid2)
  );

`ifdef RAM_MP_WRITE_BYPASS_EN
  localparam logic [7:0] SAME_9 = 8'h03;
  localparam logic [7:0] SAME_0 = 8'h7E;
`else
  localparam logic [7:0] SAME_9 = 8'h9A;
  localparam logic [7:0] SAME_0 = 8'h00;
`endif

  typedef struct {
    logic       we;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic [1:0] re;
    logic [3:0] ra0;
    logic [3:0] ra1;
    logic [1:0] exp_rv;
    logic [7:0] exp_d0;
    logic [7:0] exp_d1;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic w, logic [3:0] wa, logic [7:0] wd, logic [1:0] r,
                              logic [3:0] a0, logic [3:0] a1, logic [1:0] erv,
                              logic [7:0] e0, logic [7:0] e1);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd; v.re = r; v.ra0 = a0; v.ra1 = a1;
    v.exp_rv = erv; v.exp_d0 = e0; v.exp_d1 = e1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; re = '0; raddr = '0;
    rst2 = 1'b1; we2 = 1'b0; waddr2 = '0; wdata2 = '0; re2 = '0; raddr2 = '0;

    // Reset state
    step();
    $display("[TB] reset applied");
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    chk("nc_reset_busy", 32'(busy2), 32'd0);
    chk("nc_reset_rvalid", 32'(rvalid2), 32'd0);
    rst = 1'b0;

    // Let the clear run to ctr = 7, then restart it with rst
    for (int i = 0; i < 7; i++) begin
      step();
      chk("clear_pre_busy", 32'(busy), 32'd1);
    end
    rst = 1'b1;
    step();
    $display("[TB] reset asserted mid-clear");
    chk("restart_busy", 32'(busy), 32'd1);
    rst = 1'b0;

    // Busy must last exactly 16 cycles; writes and reads during it are dropped
    we = 1'b1; waddr = 4'h3; wdata = 8'hAA; re = 2'b11; raddr = {4'h3, 4'h3};
    for (int i = 1; i <= 16; i++) begin
      step();
      $display("[TB] clear cycle %0d busy=%0b rvalid=%b", i, busy, rvalid);
      chk("clear_busy", 32'(busy), (i < 16) ? 32'd1 : 32'd0);
      chk("clear_rvalid", 32'(rvalid), 32'd0);
    end
    chk("clear_rdata_hold", 32'(rdata), 32'd0);
    we = 1'b0; re = 2'b00;

    // Directed vector table
    for (int a = 0; a < 16; a++)
      vecs.push_back(mk(1'b0, 4'h0, 8'h00, 2'b01, 4'(a), 4'h0, 2'b01, 8'h00, 8'h00));
    vecs.push_back(mk(1'b1, 4'h2, 8'h56, 2'b00, 4'h0, 4'h0, 2'b00, 8'h00, 8'h00));
    vecs.push_back(mk(1'b1, 4'h9, 8'h9A, 2'b00, 4'h0, 4'h0, 2'b00, 8'h00, 8'h00));
    vecs.push_back(mk(1'b0, 4'h0, 8'h00, 2'b11, 4'h2, 4'h9, 2'b11, 8'h56, 8'h9A));
    vecs.push_back(mk(1'b1, 4'h9, 8'h03, 2'b01, 4'h9, 4'h0, 2'b01, SAME_9, 8'h9A));
    vecs.push_back(mk(1'b0, 4'h0, 8'h00, 2'b01, 4'h9, 4'h0, 2'b01, 8'h03, 8'h9A));
    vecs.push_back(mk(1'b0, 4'h0, 8'h00, 2'b10, 4'h0, 4'h2, 2'b10, 8'h03, 8'h56));
    vecs.push_back(mk(1'b0, 4'h0, 8'h00, 2'b00, 4'h0, 4'h0, 2'b00, 8'h03, 8'h56));
    vecs.push_back(mk(1'b0, 4'h0, 8'h00, 2'b11, 4'h9, 4'h9, 2'b11, 8'h03, 8'h03));
    vecs.push_back(mk(1'b1, 4'h0, 8'h7E, 2'b11, 4'h2, 4'h0, 2'b11, 8'h56, SAME_0));
    vecs.push_back(mk(1'b0, 4'h0, 8'h00, 2'b11, 4'h0, 4'h0, 2'b11, 8'h7E, 8'h7E));

    for (int i = 0; i < vecs.size(); i++) begin
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      re = vecs[i].re; raddr = {vecs[i].ra1, vecs[i].ra0};
      step();
      $display("[TB] vec %0d we=%0b wa=%h wd=%h re=%b ra=%h/%h -> rv=%b d0=%h d1=%h",
               i, vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].re,
               vecs[i].ra0, vecs[i].ra1, rvalid, rdata[7:0], rdata[15:8]);
      chk("vec_busy", 32'(busy), 32'd0);
      chk("vec_rvalid", 32'(rvalid), 32'(vecs[i].exp_rv));
      chk("vec_rdata0", 32'(rdata[7:0]), 32'(vecs[i].exp_d0));
      chk("vec_rdata1", 32'(rdata[15:8]), 32'(vecs[i].exp_d1));
    end
    we = 1'b0; re = 2'b00;

    // No-clear instance: usable right after reset, write then read back
    rst2 = 1'b0; we2 = 1'b1; waddr2 = 4'h5; wdata2 = 8'h11;
    step();
    $display("[TB] nc write 5 <- 11 busy=%0b", busy2);
    chk("nc_busy", 32'(busy2), 32'd0);
    we2 = 1'b0; re2 = 1'b1; raddr2 = 4'h5;
    step();
    $display("[TB] nc read 5 -> rv=%0b d=%h", rvalid2, rdata2);
    chk("nc_rvalid", 32'(rvalid2), 32'd1);
    chk("nc_rdata", 32'(rdata2), 32'h11);
    re2 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ram_mp
